uart_sdram_loader: RTL and testbench
====================================

UART_SDRAM_LOADER -- requirements
Module: uart_sdram_loader

Interface
REQ-001 Parameter ADDR_W, default 23, SDRAM word-address width.
REQ-002 clk_clk  in  1  sole clock; UART and SDRAM Avalon slaves share it.
REQ-003 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  one-cycle pulse that begins a load.
REQ-005 i_base_addr  in  ADDR_W  first SDRAM word address; sampled on accepted start.
REQ-006 i_num_words  in  ADDR_W  number of 32-bit words to load; sampled on accepted start.
REQ-007 o_busy  out  1  high from accepted start until the done pulse.
REQ-008 o_done  out  1  one-cycle pulse when the load finishes.
REQ-009 o_overrun  out  1  sticky flag: UART status ROE seen during the load.
REQ-010 o_word_cnt  out  ADDR_W  number of words written so far.
REQ-011 uart_address  out  3; uart_chipselect, uart_read_n, uart_write_n  out  1 each; uart_writedata  out  16; uart_readdata  in  16.
REQ-012 sdram_address  out  ADDR_W; sdram_writedata  out  32; sdram_byteenable_n  out  4; sdram_chipselect, sdram_write_n, sdram_read_n  out  1 each; sdram_waitrequest  in  1.

Function
REQ-013 UART register map: 0 rxdata, 1 txdata, 2 status; status bit7 RRDY, bit6 TRDY, bit3 ROE.
REQ-014 UART access is one cycle wide: chipselect=1 and read_n=0 (or write_n=0) for exactly one cycle. For reads, readdata is sampled on the following cycle.
REQ-015 States: IDLE, POLL, POLL_WAIT, RX, RX_WAIT, WR, DONE. ECHO and ECHO_POLL also exist when REQ-027 applies.
REQ-016 IDLE to POLL on i_start. If i_num_words==0, IDLE goes to DONE instead. i_start while busy is ignored.
REQ-017 POLL issues a status read, then moves to POLL_WAIT.
  - POLL_WAIT: ROE=1 sets o_overrun; RRDY=1 goes to RX; otherwise return to POLL.
REQ-018 RX issues an rxdata read. RX_WAIT captures uart_readdata[7:0] into byte lane byte_idx.
  - Byte order is little-endian: first byte goes to [7:0].
  - byte_idx increments mod 4.
  - After lane 3, go to WR; otherwise go to POLL.
REQ-019 WR holds the following until a cycle with sdram_waitrequest=0:
  - chipselect=1, write_n=0, byteenable_n=0000;
  - address = base + o_word_cnt;
  - writedata = the packed word.
  Address and data must not change while waitrequest=1.
REQ-020 On WR acceptance, o_word_cnt increments. If it now equals num_words, go to DONE; otherwise go to POLL.
REQ-021 Address arithmetic is modulo 2^ADDR_W (wraps to 0).
REQ-022 DONE pulses o_done, clears o_busy, then returns to IDLE. o_word_cnt and o_overrun hold until the next accepted start, which clears both.
REQ-023 sdram_read_n is constantly 1. The UART and SDRAM strobes are never asserted in IDLE or DONE.

Reset
REQ-024 Reset asynchronously forces state=IDLE, all counters and flags to 0, and data registers to 0.
REQ-025 Reset forces these outputs to inactive values:
  - UART and SDRAM chipselect = 0;
  - read_n and write_n = 1;
  - o_busy = 0, o_done = 0.
REQ-026 Reset mid-load abandons the partial word. No SDRAM write is issued after reset assertion.

Configuration
REQ-027 Macro UART_ECHO_EN. When defined, each received byte is echoed back on the UART:
  - after RX_WAIT, enter ECHO_POLL, which reads status until TRDY=1;
  - then ECHO writes the byte to txdata (address 1, writedata={8'h00,byte});
  - then proceed as in REQ-018.
  When undefined, no echo states exist and uart_write_n is constantly 1.

Verification
REQ-028 base=0x000100, num=2, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211@0x100 and 0x88776655@0x101; o_word_cnt=2; one o_done pulse.
REQ-029 sdram_waitrequest held high 5 cycles during the first write -> address and data are stable for those 5 cycles; exactly one write is accepted.
REQ-030 num=0 start -> o_done pulses within 2 cycles; no UART or SDRAM strobes occur.
REQ-031 Status returns 0x0088 once -> o_overrun=1 until the next start; the load still completes.
REQ-032 base=0x7FFFFF, num=2 -> second write is at 0x000000.
REQ-033 Reset asserted after byte 2 of word 0 -> all strobes are inactive immediately; a new start loads a clean word. With UART_ECHO_EN, each byte appears on txdata only after TRDY=1.

Source files
------------

// File: rtl/uart_sdram_loader.sv
// Pulls bytes from an Avalon UART, packs them little-endian into 32-bit words and
// writes them to consecutive SDRAM word addresses. Define UART_ECHO_EN to echo each byte back.
module uart_sdram_loader #(
    parameter int ADDR_W = 23
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_num_words,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic [ADDR_W-1:0] o_word_cnt,
    output logic [2:0]        uart_address,
    output logic              uart_chipselect,
    output logic              uart_read_n,
    output logic              uart_write_n,
    output logic [15:0]       uart_writedata,
    input  logic [15:0]       uart_readdata,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [31:0]       sdram_writedata,
    output logic [3:0]        sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic              sdram_write_n,
    output logic              sdram_read_n,
    input  logic              sdram_waitrequest
);

    localparam logic [2:0]        UART_RXDATA = 3'd0;
    localparam logic [2:0]        UART_STATUS = 3'd2;
    localparam logic [ADDR_W-1:0] ZERO_W      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_W       = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef UART_ECHO_EN
    localparam logic [2:0]        UART_TXDATA = 3'd1;
`endif

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POLL      = 4'd1,
        ST_POLL_WAIT = 4'd2,
        ST_RX        = 4'd3,
        ST_RX_WAIT   = 4'd4,
        ST_WR        = 4'd5,
        ST_DONE      = 4'd6
`ifdef UART_ECHO_EN
        ,
        ST_ECHO_POLL = 4'd7,
        ST_ECHO      = 4'd8
`endif
    } state_t;

    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        case (lane)
            2'd0:    result[7:0]   = data;
            2'd1:    result[15:8]  = data;
            2'd2:    result[23:16] = data;
            2'd3:    result[31:24] = data;
            default: result        = word;
        endcase
        return result;
    endfunction

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] base_r, base_next_s;
    logic [ADDR_W-1:0] num_r, num_next_s;
    logic [ADDR_W-1:0] word_cnt_r, word_cnt_next_s;
    logic              overrun_r, overrun_next_s;
    logic [1:0]        byte_idx_r, byte_idx_next_s;
    logic [31:0]       word_r, word_next_s;
`ifdef UART_ECHO_EN
    logic [7:0]        rx_byte_r, rx_byte_next_s;
    logic              echo_phase_r, echo_phase_next_s;
`endif

    logic              uart_cs_r, uart_cs_next_s;
    logic              uart_read_n_r, uart_read_n_next_s;
    logic              uart_write_n_r, uart_write_n_next_s;
    logic [2:0]        uart_address_r, uart_address_next_s;
    logic [15:0]       uart_writedata_r, uart_writedata_next_s;
    logic              sdram_cs_r, sdram_cs_next_s;
    logic              sdram_write_n_r, sdram_write_n_next_s;
    logic [3:0]        sdram_be_n_r, sdram_be_n_next_s;
    logic [ADDR_W-1:0] sdram_address_r, sdram_address_next_s;
    logic [31:0]       sdram_writedata_r, sdram_writedata_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;

    // Only the low byte of the UART read bus carries status/data
    logic              unused_readdata_s;
    assign unused_readdata_s = ^uart_readdata[15:8];

    // Next-state and datapath update
    always_comb begin
        state_next_s    = state_r;
        base_next_s     = base_r;
        num_next_s      = num_r;
        word_cnt_next_s = word_cnt_r;
        overrun_next_s  = overrun_r;
        byte_idx_next_s = byte_idx_r;
        word_next_s     = word_r;
`ifdef UART_ECHO_EN
        rx_byte_next_s    = rx_byte_r;
        echo_phase_next_s = echo_phase_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    base_next_s     = i_base_addr;
                    num_next_s      = i_num_words;
                    word_cnt_next_s = ZERO_W;
                    overrun_next_s  = 1'b0;
                    byte_idx_next_s = 2'd0;
                    word_next_s     = 32'h0000_0000;
                    if (i_num_words == ZERO_W) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_POLL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_POLL: state_next_s = ST_POLL_WAIT;
            ST_POLL_WAIT: begin
                if (uart_readdata[3]) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
                if (uart_readdata[7]) begin
                    state_next_s = ST_RX;
                end else begin
                    state_next_s = ST_POLL;
                end
            end
            ST_RX: state_next_s = ST_RX_WAIT;
            ST_RX_WAIT: begin
                word_next_s     = insert_byte(word_r, byte_idx_r, uart_readdata[7:0]);
                byte_idx_next_s = byte_idx_r + 2'd1;
`ifdef UART_ECHO_EN
                rx_byte_next_s    = uart_readdata[7:0];
                echo_phase_next_s = 1'b0;
                state_next_s      = ST_ECHO_POLL;
`else
                if (byte_idx_r == 2'd3) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_POLL;
                end
`endif
            end
`ifdef UART_ECHO_EN
            // Phase 0 issues the status read, phase 1 looks at the returned TRDY
            ST_ECHO_POLL: begin
                if (!echo_phase_r) begin
                    echo_phase_next_s = 1'b1;
                    state_next_s      = ST_ECHO_POLL;
                end else begin
                    echo_phase_next_s = 1'b0;
                    if (uart_readdata[3]) begin
                        overrun_next_s = 1'b1;
                    end else begin
                        overrun_next_s = overrun_r;
                    end
                    if (uart_readdata[6]) begin
                        state_next_s = ST_ECHO;
                    end else begin
                        state_next_s = ST_ECHO_POLL;
                    end
                end
            end
            ST_ECHO: begin
                if (byte_idx_r == 2'd0) begin
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_POLL;
                end
            end
`endif
            ST_WR: begin
                if (!sdram_waitrequest) begin
                    word_cnt_next_s = word_cnt_r + ONE_W;
                    if ((word_cnt_r + ONE_W) == num_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_POLL;
                    end
                end else begin
                    state_next_s = ST_WR;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output values for the coming state, so every bus strobe leaves a flop
    always_comb begin
        uart_cs_next_s         = 1'b0;
        uart_read_n_next_s     = 1'b1;
        uart_write_n_next_s    = 1'b1;
        uart_address_next_s    = 3'd0;
        uart_writedata_next_s  = 16'h0000;
        sdram_cs_next_s        = 1'b0;
        sdram_write_n_next_s   = 1'b1;
        sdram_be_n_next_s      = 4'hF;
        sdram_address_next_s   = sdram_address_r;
        sdram_writedata_next_s = sdram_writedata_r;
        busy_next_s            = 1'b1;
        done_next_s            = 1'b0;
        case (state_next_s)
            ST_IDLE: busy_next_s = 1'b0;
            ST_DONE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b1;
            end
            ST_POLL: begin
                uart_cs_next_s      = 1'b1;
                uart_read_n_next_s  = 1'b0;
                uart_address_next_s = UART_STATUS;
            end
            ST_RX: begin
                uart_cs_next_s      = 1'b1;
                uart_read_n_next_s  = 1'b0;
                uart_address_next_s = UART_RXDATA;
            end
`ifdef UART_ECHO_EN
            ST_ECHO_POLL: begin
                if (!echo_phase_next_s) begin
                    uart_cs_next_s      = 1'b1;
                    uart_read_n_next_s  = 1'b0;
                    uart_address_next_s = UART_STATUS;
                end else begin
                    uart_cs_next_s      = 1'b0;
                end
            end
            ST_ECHO: begin
                uart_cs_next_s        = 1'b1;
                uart_write_n_next_s   = 1'b0;
                uart_address_next_s   = UART_TXDATA;
                uart_writedata_next_s = {8'h00, rx_byte_next_s};
            end
`endif
            // Address and data are recomputed from values that cannot move during a stall
            ST_WR: begin
                sdram_cs_next_s        = 1'b1;
                sdram_write_n_next_s   = 1'b0;
                sdram_be_n_next_s      = 4'h0;
                sdram_address_next_s   = base_next_s + word_cnt_next_s;
                sdram_writedata_next_s = word_next_s;
            end
            default: busy_next_s = 1'b1;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r           <= ST_IDLE;
            base_r            <= ZERO_W;
            num_r             <= ZERO_W;
            word_cnt_r        <= ZERO_W;
            overrun_r         <= 1'b0;
            byte_idx_r        <= 2'd0;
            word_r            <= 32'h0000_0000;
`ifdef UART_ECHO_EN
            rx_byte_r         <= 8'h00;
            echo_phase_r      <= 1'b0;
`endif
            uart_cs_r         <= 1'b0;
            uart_read_n_r     <= 1'b1;
            uart_write_n_r    <= 1'b1;
            uart_address_r    <= 3'd0;
            uart_writedata_r  <= 16'h0000;
            sdram_cs_r        <= 1'b0;
            sdram_write_n_r   <= 1'b1;
            sdram_be_n_r      <= 4'hF;
            sdram_address_r   <= ZERO_W;
            sdram_writedata_r <= 32'h0000_0000;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            base_r            <= base_next_s;
            num_r             <= num_next_s;
            word_cnt_r        <= word_cnt_next_s;
            overrun_r         <= overrun_next_s;
            byte_idx_r        <= byte_idx_next_s;
            word_r            <= word_next_s;
`ifdef UART_ECHO_EN
            rx_byte_r         <= rx_byte_next_s;
            echo_phase_r      <= echo_phase_next_s;
`endif
            uart_cs_r         <= uart_cs_next_s;
            uart_read_n_r     <= uart_read_n_next_s;
            uart_write_n_r    <= uart_write_n_next_s;
            uart_address_r    <= uart_address_next_s;
            uart_writedata_r  <= uart_writedata_next_s;
            sdram_cs_r        <= sdram_cs_next_s;
            sdram_write_n_r   <= sdram_write_n_next_s;
            sdram_be_n_r      <= sdram_be_n_next_s;
            sdram_address_r   <= sdram_address_next_s;
            sdram_writedata_r <= sdram_writedata_next_s;
            busy_r            <= busy_next_s;
            done_r            <= done_next_s;
        end
    end

    assign o_busy             = busy_r;
    assign o_done             = done_r;
    assign o_overrun          = overrun_r;
    assign o_word_cnt         = word_cnt_r;
    assign uart_address       = uart_address_r;
    assign uart_chipselect    = uart_cs_r;
    assign uart_read_n        = uart_read_n_r;
    assign uart_write_n       = uart_write_n_r;
    assign uart_writedata     = uart_writedata_r;
    assign sdram_address      = sdram_address_r;
    assign sdram_writedata    = sdram_writedata_r;
    assign sdram_byteenable_n = sdram_be_n_r;
    assign sdram_chipselect   = sdram_cs_r;
    assign sdram_write_n      = sdram_write_n_r;
    assign sdram_read_n       = 1'b1;

endmodule

// File: tb/tb_uart_sdram_loader.sv
// Scoreboard bench for uart_sdram_loader: UART/SDRAM slave models, reference word packing,
// randomized loads plus directed wrap, stall, overrun, zero-length and mid-load reset cases.
`timescale 1ns/1ps
module tb_uart_sdram_loader;
    localparam int ADDR_W = 23;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n = 1'b1;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [ADDR_W-1:0] i_num_words = '0;
    logic              o_busy, o_done, o_overrun;
    logic [ADDR_W-1:0] o_word_cnt;
    logic [2:0]        uart_address;
    logic              uart_chipselect, uart_read_n, uart_write_n;
    logic [15:0]       uart_writedata;
    logic [15:0]       uart_readdata;
    logic [ADDR_W-1:0] sdram_address;
    logic [31:0]       sdram_writedata;
    logic [3:0]        sdram_byteenable_n;
    logic              sdram_chipselect, sdram_write_n, sdram_read_n;
    logic              sdram_waitrequest;

    uart_sdram_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_num_words(i_num_words), .o_busy(o_busy),
        .o_done(o_done), .o_overrun(o_overrun), .o_word_cnt(o_word_cnt),
        .uart_address(uart_address), .uart_chipselect(uart_chipselect),
        .uart_read_n(uart_read_n), .uart_write_n(uart_write_n),
        .uart_writedata(uart_writedata), .uart_readdata(uart_readdata),
        .sdram_address(sdram_address), .sdram_writedata(sdram_writedata),
        .sdram_byteenable_n(sdram_byteenable_n), .sdram_chipselect(sdram_chipselect),
        .sdram_write_n(sdram_write_n), .sdram_read_n(sdram_read_n),
        .sdram_waitrequest(sdram_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [ADDR_W-1:0] cnt; logic ovr; } done_t;

    wr_t        exp_wr_q[$];
    done_t      exp_done_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] echo_q[$];
    logic [7:0] stim_bytes[$];

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART slave: registered read data, random RRDY/TRDY, optional one-shot ROE
    bit   roe_pending = 1'b0;
    logic last_trdy = 1'b0;
    logic sl_rrdy, sl_trdy, sl_roe;
    int   rx_reads = 0;
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            uart_readdata <= 16'h0000;
        end else if (uart_chipselect && !uart_read_n) begin
            if (uart_address == 3'd2) begin
                sl_rrdy = (rx_q.size() > 0) && ($urandom_range(0, 3) != 0);
                sl_trdy = ($urandom_range(0, 1) == 1);
                sl_roe  = 1'b0;
                if (roe_pending && sl_rrdy) begin
                    sl_roe = 1'b1;
                    sl_trdy = 1'b0;
                    roe_pending = 1'b0;
                end
                last_trdy = sl_trdy;
                uart_readdata <= {8'h00, sl_rrdy, sl_trdy, 2'b00, sl_roe, 3'b000};
            end else if (uart_address == 3'd0) begin
                rx_reads++;
                if (rx_q.size() > 0) uart_readdata <= {8'h00, rx_q.pop_front()};
                else uart_readdata <= 16'h00EE;
            end else begin
                uart_readdata <= 16'h0000;
            end
        end
    end

    // SDRAM slave: stalls each write for stall_target cycles
    int force_stall = 0;
    int stall_cnt = 0;
    int stall_target = 0;
    assign sdram_waitrequest = sdram_chipselect && !sdram_write_n && (stall_cnt < stall_target);
    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stall_cnt <= 0;
            stall_target <= 0;
        end else if (sdram_chipselect && !sdram_write_n) begin
            if (sdram_waitrequest) stall_cnt <= stall_cnt + 1;
            else begin
                stall_cnt <= 0;
                force_stall = 0;
            end
        end else begin
            stall_cnt <= 0;
            stall_target <= (force_stall > 0) ? force_stall : int'($urandom_range(0, 2));
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a write, echo or done
    int  stall_seen = 0, last_stall_seen = 0;
    bit  prev_stall = 1'b0, prev_uart_cs = 1'b0, prev_done = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    int  unstable = 0, idle_strobe = 0, read_n_bad = 0, uart_wide = 0;
    int  uart_write_cnt = 0, uart_strobe_cnt = 0, sdram_strobe_cnt = 0;
    int  sdram_accepts = 0, done_cnt = 0;
    wr_t   mon_wr;
    done_t mon_done;
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            prev_stall = 1'b0; prev_uart_cs = 1'b0; prev_done = 1'b0; stall_seen = 0;
        end else begin
            if (sdram_read_n !== 1'b1) read_n_bad++;
            if (!o_busy && (uart_chipselect || sdram_chipselect)) idle_strobe++;
            if (uart_chipselect && prev_uart_cs) uart_wide++;
            prev_uart_cs = uart_chipselect;
            if (uart_chipselect) uart_strobe_cnt++;
            if (sdram_chipselect) sdram_strobe_cnt++;
            if (sdram_chipselect && !sdram_write_n) begin
                if (prev_stall && (sdram_address !== prev_addr || sdram_writedata !== prev_data))
                    unstable++;
                if (sdram_waitrequest) begin
                    stall_seen++;
                    prev_stall = 1'b1;
                    prev_addr = sdram_address;
                    prev_data = sdram_writedata;
                end else begin
                    sdram_accepts++;
                    last_stall_seen = stall_seen;
                    if (exp_wr_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL sdram_write: unexpected write addr 0x%0h data 0x%0h, expected none",
                                 sdram_address, sdram_writedata);
                    end else begin
                        mon_wr = exp_wr_q.pop_front();
                        chk("sdram_addr", 64'(sdram_address), 64'(mon_wr.addr));
                        chk("sdram_data", 64'(sdram_writedata), 64'(mon_wr.data));
                        chk("sdram_byteenable_n", 64'(sdram_byteenable_n), 64'h0);
                    end
                    stall_seen = 0;
                    prev_stall = 1'b0;
                end
            end else begin
                stall_seen = 0;
                prev_stall = 1'b0;
            end
            if (uart_chipselect && !uart_write_n) begin
                uart_write_cnt++;
`ifdef UART_ECHO_EN
                chk("echo_addr", 64'(uart_address), 64'd1);
                chk("echo_after_trdy", 64'(last_trdy), 64'd1);
                if (echo_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL echo_data: unexpected 0x%0h, expected none", uart_writedata);
                end else begin
                    chk("echo_data", 64'(uart_writedata), 64'({8'h00, echo_q.pop_front()}));
                end
`endif
            end
            if (o_done) begin
                done_cnt++;
                chk("done_busy_low", 64'(o_busy), 64'd0);
                chk("done_one_cycle", 64'(prev_done), 64'd0);
                if (exp_done_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL done: unexpected pulse, word_cnt 0x%0h, expected none", o_word_cnt);
                end else begin
                    mon_done = exp_done_q.pop_front();
                    chk("done_word_cnt", 64'(o_word_cnt), 64'(mon_done.cnt));
                    chk("done_overrun", 64'(o_overrun), 64'(mon_done.ovr));
                end
            end
            prev_done = o_done;
        end
    end

    task automatic fill_random(input int n);
        stim_bytes.delete();
        for (int i = 0; i < n; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference model: word k = bytes 4k..4k+3 little-endian at (base + k) mod 2^ADDR_W
    task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] num,
                              input bit roe);
        wr_t   w;
        done_t d;
        for (int k = 0; k < int'(num); k++) begin
            w.data = 32'h0;
            for (int b = 0; b < 4; b++) w.data = w.data + (32'(stim_bytes[4*k+b]) << (8*b));
            w.addr = ADDR_W'((longint'(base) + longint'(k)) % (longint'(1) << ADDR_W));
            exp_wr_q.push_back(w);
        end
        for (int i = 0; i < 4 * int'(num); i++) begin
            rx_q.push_back(stim_bytes[i]);
            echo_q.push_back(stim_bytes[i]);
        end
        d.cnt = num;
        d.ovr = roe;
        exp_done_q.push_back(d);
        roe_pending = roe;
        @(negedge clk_clk);
        i_base_addr = base;
        i_num_words = num;
        i_start = 1'b1;
        @(negedge clk_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input string name);
        int n = 0;
        while (done_cnt == start_cnt && n < 5000) begin
            @(negedge clk_clk);
            n++;
        end
        if (done_cnt == start_cnt) begin
            compared++; mismatched++;
            $display("FAIL %s: no done pulse within 5000 cycles, expected one", name);
        end
        @(negedge clk_clk);
        chk({name, "_writes_outstanding"}, 64'(exp_wr_q.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, s0, u0, r0, n;
        #1 reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_word_cnt", 64'(o_word_cnt), 64'd0);
        chk("reset_overrun", 64'(o_overrun), 64'd0);
        chk("reset_uart_strobes", 64'({uart_chipselect, uart_read_n, uart_write_n}), 64'b011);
        chk("reset_sdram_strobes", 64'({sdram_chipselect, sdram_write_n, sdram_read_n}), 64'b011);
        reset_reset_n = 1'b1;
        repeat (2) @(negedge clk_clk);

        // Fixed byte sequence 11..88 into two words at 0x100
        stim_bytes.delete();
        for (int i = 1; i <= 8; i++) stim_bytes.push_back(8'(i * 17));
        d0 = done_cnt;
        start_load(23'h000100, 23'd2, 1'b0);
        wait_done(d0, "fixed_bytes");
        chk("fixed_word_cnt_hold", 64'(o_word_cnt), 64'd2);

        // Five-cycle stall on the first write
        fill_random(8);
        force_stall = 5;
        a0 = sdram_accepts;
        d0 = done_cnt;
        start_load(23'(($urandom_range(0, 1000))), 23'd2, 1'b0);
        n = 0;
        while (sdram_accepts == a0 && n < 3000) begin
            @(negedge clk_clk);
            n++;
        end
        chk("stall_cycles_first_write", 64'(last_stall_seen), 64'd5);
        wait_done(d0, "stall");
        chk("stall_accept_count", 64'(sdram_accepts - a0), 64'd2);

        // Zero-length load
        s0 = uart_strobe_cnt + sdram_strobe_cnt;
        d0 = done_cnt;
        start_load(23'h000055, 23'd0, 1'b0);
        n = 0;
        while (done_cnt == d0 && n < 10) begin
            @(negedge clk_clk);
            n++;
        end
        chk("zero_len_done_latency", 64'(n <= 2), 64'd1);
        repeat (3) @(negedge clk_clk);
        chk("zero_len_no_strobes", 64'(uart_strobe_cnt + sdram_strobe_cnt - s0), 64'd0);
        chk("zero_len_word_cnt", 64'(o_word_cnt), 64'd0);

        // One status read carries ROE; load completes, flag sticks
        fill_random(8);
        d0 = done_cnt;
        start_load(23'(($urandom_range(0, 5000))), 23'd2, 1'b1);
        wait_done(d0, "overrun");
        repeat (5) @(negedge clk_clk);
        chk("overrun_hold", 64'(o_overrun), 64'd1);

        // Address wrap at the top of the word space; start clears overrun and count
        fill_random(8);
        d0 = done_cnt;
        start_load(23'h7FFFFF, 23'd2, 1'b0);
        chk("start_clears_overrun", 64'(o_overrun), 64'd0);
        chk("start_clears_word_cnt", 64'(o_word_cnt), 64'd0);
        wait_done(d0, "wrap");

        // Start pulse while busy must be ignored
        fill_random(8);
        d0 = done_cnt;
        start_load(23'h001234, 23'd2, 1'b0);
        repeat (15) @(negedge clk_clk);
        chk("busy_during_load", 64'(o_busy), 64'd1);
        i_base_addr = 23'h000777;
        i_num_words = 23'd1;
        i_start = 1'b1;
        @(negedge clk_clk);
        i_start = 1'b0;
        wait_done(d0, "start_while_busy");

        // Reset during word 0, then a clean load
        fill_random(8);
        r0 = rx_reads;
        start_load(23'h000400, 23'd2, 1'b0);
        n = 0;
        while ((rx_reads - r0) < 2 && n < 3000) begin
            @(negedge clk_clk);
            n++;
        end
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("midreset_uart_strobes", 64'({uart_chipselect, uart_read_n, uart_write_n}), 64'b011);
        chk("midreset_sdram_strobes", 64'({sdram_chipselect, sdram_write_n}), 64'b01);
        chk("midreset_busy", 64'(o_busy), 64'd0);
        exp_wr_q.delete();
        exp_done_q.delete();
        rx_q.delete();
        echo_q.delete();
        roe_pending = 1'b0;
        a0 = sdram_accepts;
        u0 = done_cnt;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        chk("midreset_no_write", 64'(sdram_accepts - a0), 64'd0);
        chk("midreset_no_done", 64'(done_cnt - u0), 64'd0);
        fill_random(4);
        d0 = done_cnt;
        start_load(23'h000400, 23'd1, 1'b0);
        wait_done(d0, "after_reset");

        // Randomized loads
        for (int i = 0; i < 5; i++) begin
            fill_random(12);
            d0 = done_cnt;
            start_load(23'($urandom_range(0, (1 << ADDR_W) - 1)),
                       23'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
            wait_done(d0, "random_load");
        end

        repeat (5) @(negedge clk_clk);
        chk("addr_data_stable_in_stall", 64'(unstable), 64'd0);
        chk("no_strobe_when_idle", 64'(idle_strobe), 64'd0);
        chk("sdram_read_n_high", 64'(read_n_bad), 64'd0);
        chk("uart_strobe_one_cycle", 64'(uart_wide), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
`ifndef UART_ECHO_EN
        chk("uart_write_strobes", 64'(uart_write_cnt), 64'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
